overlap_add: RTL
================

Name: overlap_add

Overview:
- Synthesis-side counterpart of the analysis windowing stage: takes a whole parallel frame of windowed samples and turns it back into a serial sample stream.
- Uses 50% overlap-add: each accepted frame yields HOP_SIZE output samples, each the sum of the current frame's first half and the previous frame's stored second half.
- Sits after per-frame processing and before the sample-rate output path (DAC/FIFO).

Parameters:
SAMPLE_BITS, 12, width of each unsigned input/output sample
WINDOW_SIZE, 128, samples per input frame; power of two, >= 4
HOP_SIZE, WINDOW_SIZE/2, output samples per frame; fixed at WINDOW_SIZE/2 (other values illegal)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets)
in  input  SAMPLE_BITS x [0:WINDOW_SIZE-1]  parallel frame, unpacked array, index 0 oldest
in_valid  input  1  frame on `in` is valid
in_ready  output  1  block can accept a frame this cycle
out  output  SAMPLE_BITS  serial overlap-added sample
out_valid  output  1  `out` holds a valid sample
out_ready  input  1  downstream accepts `out` this cycle
out_first  output  1  high with the first sample (index 0) of each hop

Behaviour:
- Reset (rst==0 at posedge):
  - state<=IDLE, out<=0, out_valid<=0, out_first<=0, index<=0.
  - Frame buffer and tail buffer (HOP_SIZE entries) cleared to 0.
  - in_ready is low while rst==0.
- Reset mid-EMIT: the in-flight frame is discarded, the tail is cleared, and no further samples from that frame are emitted.
- States: IDLE, EMIT.
- in_ready = (state==IDLE) && rst==1. This is combinational from state only and never depends on in_valid or out_ready.
- IDLE:
  - Frame is accepted on a cycle with in_valid && in_ready: latch in[0:WINDOW_SIZE-1] into the frame buffer, index<=0, go to EMIT.
  - Same edge: register out<=sat(in[0]+tail[0]), out_valid<=1, out_first<=1.
  - Latency: a frame accepted at edge T has sample 0 visible after edge T.
- EMIT:
  - `out` holds sample `index` until a handshake (out_valid && out_ready).
  - `out`, out_valid and out_first are stable while out_ready is low.
  - On handshake with index < HOP_SIZE-1: index<=index+1, out<=sat(buf[index+1]+tail[index+1]), out_first<=0.
  - On handshake with index == HOP_SIZE-1: tail[k]<=buf[HOP_SIZE+k] for all k, out_valid<=0, out_first<=0, index<=0, state<=IDLE.
  - Exactly one idle bubble cycle occurs between frames (in_ready high in IDLE).
- Arithmetic:
  - Sum width is SAMPLE_BITS+1, both operands unsigned.
  - sat(x) = (x > 2^SAMPLE_BITS-1) ? 2^SAMPLE_BITS-1 : x[SAMPLE_BITS-1:0].
  - No rounding, no scaling; the analysis window handles amplitude.
- The first frame after reset overlaps with a zero tail, so its output equals the frame's first half.
- in_valid while in EMIT is ignored; upstream must hold the frame until in_ready.
- out_valid never drops without a handshake except on reset.
- Index counter is $clog2(HOP_SIZE) bits and never wraps past HOP_SIZE-1.
- Throughput: HOP_SIZE+1 cycles per frame with out_ready held high.

Test Plan:
- Reset release, in_valid=0 → out=0, out_valid=0, in_ready=1; hold 10 cycles, no change.
- After reset, one frame in[k]=k (k=0..127), out_ready=1 → 64 outputs 0..63 on consecutive cycles; out_first only on the first; in_ready returns high the cycle after the 64th.
- Second frame in[k]=1000 following the first → outputs 1000+64..1000+127, i.e. 1064..1127 (tail from frame 1 added).
- Saturation: tail entries 4000, next frame first half 200 → out=4095 for all 64 samples.
- Backpressure: toggle out_ready 1,0,0,1,... → out/out_valid held while out_ready=0; no sample dropped or duplicated; in_valid pulses during EMIT are ignored.
- rst=0 asserted at index 30 of a frame → next cycle out_valid=0, out=0; next frame in[k]=5 yields out=5 for all 64 samples (tail cleared).

Source files
------------

// File: rtl/overlap_add.sv
// 50% overlap-add synthesis stage: accepts a whole windowed frame in parallel and
// streams out HOP_SIZE samples, each the saturated sum of the frame's first half and the previous frame's second half.
module overlap_add #(
    parameter int unsigned SAMPLE_BITS = 12,
    parameter int unsigned WINDOW_SIZE = 128,
    parameter int unsigned HOP_SIZE    = WINDOW_SIZE / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_BITS-1:0] in [0:WINDOW_SIZE-1],
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [SAMPLE_BITS-1:0] out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_first
);

    localparam int unsigned IDX_BITS = $clog2(HOP_SIZE);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(HOP_SIZE - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                 state;
    logic [IDX_BITS-1:0]    index;
    logic [IDX_BITS-1:0]    next_index;
    logic [SAMPLE_BITS-1:0] head_buf [0:HOP_SIZE-1];
    logic [SAMPLE_BITS-1:0] back_buf [0:HOP_SIZE-1];
    logic [SAMPLE_BITS-1:0] tail     [0:HOP_SIZE-1];

    function automatic logic [SAMPLE_BITS-1:0] sat_add(input logic [SAMPLE_BITS-1:0] a,
                                                       input logic [SAMPLE_BITS-1:0] b);
        logic [SAMPLE_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SAMPLE_BITS] ? '1 : sum[SAMPLE_BITS-1:0];
    endfunction

    assign in_ready   = (state == IDLE) && rst;
    assign next_index = index + 1'b1;

    // Frame is split into two HOP-sized halves so every lookup uses the narrow index directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            index     <= '0;
            for (int unsigned k = 0; k < HOP_SIZE; k++) begin
                head_buf[k] <= '0;
                back_buf[k] <= '0;
                tail[k]     <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < HOP_SIZE; k++) begin
                            head_buf[k] <= in[k];
                            back_buf[k] <= in[HOP_SIZE + k];
                        end
                        index     <= '0;
                        out       <= sat_add(in[0], tail[0]);
                        out_valid <= 1'b1;
                        out_first <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (index == LAST_IDX) begin
                            for (int unsigned k = 0; k < HOP_SIZE; k++) begin
                                tail[k] <= back_buf[k];
                            end
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            index     <= '0;
                            state     <= IDLE;
                        end else begin
                            index     <= next_index;
                            out       <= sat_add(head_buf[next_index], tail[next_index]);
                            out_first <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
